// File: rtl/out_bcd_conv.sv
// Binary-to-packed-BCD converter for the CPU `out` port, using a sequential double-dabble engine.
// Define OUT_BCD_SIGNED_EN to treat `in` as two's complement and report the sign separately.
module out_bcd_conv #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DIGITS     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic                  valid,
  output logic                  busy
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic [DATA_WIDTH-1:0] opr_q, opr_d;
  logic [BCD_W-1:0]      scr_q, scr_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  logic [BCD_W-1:0]      adj;
  logic [DATA_WIDTH-1:0] mag;

`ifdef OUT_BCD_SIGNED_EN
  logic                  sign_pend_q, sign_pend_d;
  logic                  sign_q, sign_d;
  logic [DATA_WIDTH-1:0] in_neg;

  // The most negative input wraps to itself, which reads correctly as the unsigned magnitude.
  assign in_neg = ~in + DATA_WIDTH'(1);
  assign mag    = in[DATA_WIDTH-1] ? in_neg : in;
  assign sign   = sign_q;
`else
  assign mag  = in;
  assign sign = 1'b0;
`endif

  // Double-dabble correction: bump every digit of 5 or more before it is doubled.
  always_comb begin
    adj = scr_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    opr_d   = opr_q;
    scr_d   = scr_q;
    bcd_d   = bcd_q;
    valid_d = 1'b0;
`ifdef OUT_BCD_SIGNED_EN
    sign_pend_d = sign_pend_q;
    sign_d      = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (in != last_q) begin
          last_d  = in;
          opr_d   = mag;
          scr_d   = '0;
          cnt_d   = CNT_W'(DATA_WIDTH);
          state_d = CONV;
`ifdef OUT_BCD_SIGNED_EN
          sign_pend_d = in[DATA_WIDTH-1];
`endif
        end
      end
      CONV: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          scr_d = {adj[BCD_W-2:0], opr_q[DATA_WIDTH-1]};
          opr_d = {opr_q[DATA_WIDTH-2:0], 1'b0};
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        bcd_d   = scr_q;
        valid_d = 1'b1;
        state_d = IDLE;
`ifdef OUT_BCD_SIGNED_EN
        sign_d  = sign_pend_q;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      opr_q   <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      opr_q   <= opr_d;
      scr_q   <= scr_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

`ifdef OUT_BCD_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_pend_q <= 1'b0;
      sign_q      <= 1'b0;
    end else begin
      sign_pend_q <= sign_pend_d;
      sign_q      <= sign_d;
    end
  end
`endif

  assign bcd   = bcd_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_out_bcd_conv.sv
// Directed bench for out_bcd_conv: vector table plus hand-written multi-cycle sequences.
module tb_out_bcd_conv;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic [19:0] bcd;
  logic        sign;
  logic        valid;
  logic        busy;

  int errors = 0;
  int checks = 0;

  out_bcd_conv #(.DATA_WIDTH(16), .DIGITS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .bcd   (bcd),
    .sign  (sign),
    .valid (valid),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    logic [19:0] bcd_u;
    logic [19:0] bcd_s;
    logic        sgn_s;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Caller sits just after a falling edge; the next rising edge samples val.
  task automatic run_conv(input logic [15:0] val, input logic [19:0] exp_bcd,
                          input logic exp_sign, input string name);
    logic [19:0] prev;
    int          bad;
    prev = bcd;
    bad  = 0;
    in   = val;
    @(posedge clk); #1;
    chk({name, " busy_rise"}, 32'(busy), 32'd1);
    chk({name, " no_early_valid"}, 32'(valid), 32'd0);
    for (int k = 1; k < 18; k++) begin
      @(posedge clk); #1;
      if (valid !== 1'b0 || bcd !== prev || busy !== 1'b1) bad++;
    end
    chk({name, " held_during_conv"}, 32'(bad), 32'd0);
    @(posedge clk); #1;
    chk({name, " valid"}, 32'(valid), 32'd1);
    chk({name, " bcd"}, 32'(bcd), 32'(exp_bcd));
    chk({name, " sign"}, 32'(sign), 32'(exp_sign));
    chk({name, " busy_low"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({name, " valid_one_cycle"}, 32'(valid), 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    logic [19:0] eb;
    logic        es;
    int          bad;
    int          nvalid;
    int          v1_at, v2_at;
    logic [19:0] v1_bcd, v2_bcd;
    int          saw200;

    vecs[0] = '{16'h04D2, 20'h01234, 20'h01234, 1'b0};
    vecs[1] = '{16'hFFFF, 20'h65535, 20'h00001, 1'b1};
    vecs[2] = '{16'h8000, 20'h32768, 20'h32768, 1'b1};
    vecs[3] = '{16'h0001, 20'h00001, 20'h00001, 1'b0};
    vecs[4] = '{16'h270F, 20'h09999, 20'h09999, 1'b0};
    vecs[5] = '{16'h2710, 20'h10000, 20'h10000, 1'b0};
    vecs[6] = '{16'h7FFF, 20'h32767, 20'h32767, 1'b0};
    vecs[7] = '{16'hFB2E, 20'h64302, 20'h01234, 1'b1};
    vecs[8] = '{16'h0063, 20'h00099, 20'h00099, 1'b0};
    vecs[9] = '{16'h0000, 20'h00000, 20'h00000, 1'b0};

    rst_n = 1'b0;
    in    = 16'h0000;
    #12;
    chk("reset bcd", 32'(bcd), 32'd0);
    chk("reset sign", 32'(sign), 32'd0);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // A zero input right after reset matches the stored value and must stay idle.
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || valid !== 1'b0) bad++;
    end
    chk("zero_after_reset idle", 32'(bad), 32'd0);

    for (int i = 0; i < 10; i++) begin
`ifdef OUT_BCD_SIGNED_EN
      eb = vecs[i].bcd_s;
      es = vecs[i].sgn_s;
`else
      eb = vecs[i].bcd_u;
      es = 1'b0;
`endif
      @(negedge clk);
      run_conv(vecs[i].val, eb, es, $sformatf("vec%0d", i));
    end

    // Holding the same value must not retrigger.
    @(negedge clk);
    run_conv(16'd42, 20'h00042, 1'b0, "hold42");
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || valid !== 1'b0) bad++;
    end
    chk("hold42 quiet", 32'(bad), 32'd0);

    // Input changes during a conversion: only the latest value follows.
    @(negedge clk);
    in = 16'd100;
    @(posedge clk);
    nvalid = 0; v1_at = -1; v2_at = -1; v1_bcd = '0; v2_bcd = '0; saw200 = 0;
    for (int c = 1; c <= 42; c++) begin
      @(posedge clk); #1;
      if (bcd === 20'h00200) saw200++;
      if (valid === 1'b1) begin
        nvalid++;
        if (nvalid == 1) begin v1_at = c; v1_bcd = bcd; end
        else if (nvalid == 2) begin v2_at = c; v2_bcd = bcd; end
      end
      if (c == 3) in = 16'd200;
      if (c == 8) in = 16'd300;
    end
    chk("retrig valid_count", 32'(nvalid), 32'd2);
    chk("retrig first_at", 32'(v1_at), 32'd18);
    chk("retrig first_bcd", 32'(v1_bcd), 32'h00100);
    chk("retrig second_at", 32'(v2_at), 32'd37);
    chk("retrig second_bcd", 32'(v2_bcd), 32'h00300);
    chk("retrig never_200", 32'(saw200), 32'd0);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    in = 16'd9999;
    @(posedge clk);
    repeat (7) @(posedge clk);
    #1;
    chk("midreset busy_before", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset bcd", 32'(bcd), 32'd0);
    chk("midreset sign", 32'(sign), 32'd0);
    chk("midreset valid", 32'(valid), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_conv(16'd9999, 20'h09999, 1'b0, "after_reset9999");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/out_bcd_conv.md
OUT_BCD_CONV -- requirements
Module: out_bcd_conv

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the binary operand; the sequencing and checks below assume 16.
REQ-002 Parameter DIGITS, default 5: number of BCD digits produced; must satisfy 10^DIGITS > 2^DATA_WIDTH.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in  input  DATA_WIDTH  binary value driven by the CPU `out` port.
REQ-006 bcd  output  4*DIGITS  registered packed BCD; digit 0 in bits [3:0].
REQ-007 sign  output  1  registered sign of the value in bcd; 1 = negative.
REQ-008 valid  output  1  one-cycle pulse marking that bcd/sign have just updated.
REQ-009 busy  output  1  high while a conversion is in progress.

Function
REQ-010 The FSM SHALL have three states: IDLE, CONV and DONE.
REQ-011 In IDLE, when in differs from the stored last_value, the edge SHALL do four things:
  - latch in into last_value
  - load the operand shift register
  - clear the BCD scratch
  - set the bit counter to DATA_WIDTH and enter CONV.
REQ-012 In IDLE with in equal to last_value, the block SHALL remain idle, and bcd, sign and valid SHALL remain unchanged.
REQ-013 Each CONV edge SHALL do three things:
  - add 3 to every scratch digit that is 5 or more
  - shift {scratch, operand} left by one bit
  - decrement the counter.
REQ-014 When the counter reaches 0, the block SHALL enter DONE.
REQ-015 The DONE edge SHALL copy scratch to bcd, update sign, assert valid for exactly one cycle and return to IDLE.
REQ-016 bcd SHALL update exactly DATA_WIDTH+2 edges after the sampling edge (18 for 16 bits), and valid SHALL be high in that same cycle.
REQ-017 busy SHALL be high in CONV and DONE and low in IDLE.
REQ-018 Changes on in while busy SHALL be ignored. On return to IDLE, if in differs from last_value, a new conversion SHALL start at the next edge, so only the latest value is converted.
REQ-019 bcd SHALL change only on the DONE edge, so intermediate scratch values never appear on bcd.
REQ-020 Every digit of bcd SHALL always hold a value from 0 to 9.

Reset
REQ-021 Asserting rst_n low SHALL immediately apply the reset values below, including mid-conversion:
  - state IDLE, counter 0
  - last_value 0, bcd 0, sign 0
  - valid 0, busy 0.
REQ-022 After reset is released, an in value of 0 SHALL not trigger a conversion, because it matches last_value.

Configuration
REQ-023 Macro OUT_BCD_SIGNED_EN defined: in SHALL be treated as two's complement.
  - The sampling edge SHALL load the magnitude as unsigned: in if in[MSB]=0, otherwise ~in+1.
  - The sampling edge SHALL also capture in[MSB] for sign.
  - The most negative value SHALL convert as magnitude 2^(DATA_WIDTH-1).
REQ-024 Macro OUT_BCD_SIGNED_EN undefined: in SHALL be treated as unsigned, and sign SHALL be constant 0 with no sign or negation logic compiled.

Verification
REQ-025 Drive in=16'h04D2 from idle -> busy rises the next cycle; 18 edges after sampling, bcd=20'h01234, sign=0, valid is high for one cycle.
REQ-026 Drive in=16'hFFFF -> unsigned build: bcd=20'h65535, sign=0; signed build: bcd=20'h00001, sign=1.
REQ-027 Signed build, in=16'h8000 -> bcd=20'h32768, sign=1.
REQ-028 Hold in=16'd42 after its conversion completes -> no further busy or valid activity over 50 cycles.
REQ-029 Change in from 100 to 200 and then 300 during a conversion -> bcd=20'h00100 first; then exactly one further conversion yields 20'h00300; 200 never appears on bcd.
REQ-030 Pulse rst_n low at CONV step 7 of in=9999 -> all outputs are 0 at once with no valid. After release, re-driving 9999 gives bcd=20'h09999 18 edges after the sampling edge.
